pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register that supersedes the fixed per-stage flop banks (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control field and a data payload between stages, with a valid/ready handshake for stalls and a synchronous flush that inserts a bubble. An optional two-entry skid buffer breaks the combinational ready path between stages. One instance is placed per pipeline boundary.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_entry.sv | 32 +++
 rtl/pipe_stage_reg.sv | 94 +++++++++
 tb/tb_pipe_stage_reg.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: control-field width, control bit layout, per-boundary payload widths.
// No logic; imported by every pipe stage register.
package pipe_pkg;

  localparam int PIPE_CTRL_W = 23;

  // Control field layout, LSB first.
  localparam int ALU_OP_LSB         = 0;   // 4 bits
  localparam int BRANCH_JUMP_OP_LSB = 4;   // 3 bits
  localparam int EXT_OP_LSB         = 7;   // 2 bits
  localparam int DST_REG_LSB        = 9;   // 2 bits
  localparam int PC_SRC_LSB         = 11;  // 2 bits
  localparam int ALU_SRC_BIT        = 13;
  localparam int EXT_SIGN_BIT       = 14;
  localparam int REG_WRITE_BIT      = 15;
  localparam int MEM_READ_BIT       = 16;
  localparam int MEM_WRITE_BIT      = 17;
  localparam int JAL_BIT            = 18;
  localparam int MEM_REG_BIT        = 19;
  localparam int MEM_EN_BIT         = 20;
  localparam int EXCP_LSB           = 21;  // 2 bits

  // Payload widths for each pipeline boundary.
  localparam int IF_ID_DATA_W   = 32;
  localparam int ID_EX_DATA_W   = 72;
  localparam int EX_MEM_DATA_W  = 56;
  localparam int MEM_WB_DATA_W  = 40;

endpackage

// File: rtl/pipe_entry.sv
// One storage slot (valid + ctrl + data): 1-cycle load; clear/reset zero everything so an empty slot shows ctrl=0.
// No backpressure of its own; the owning stage decides when to load or clear.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= load_ctrl;
      data  <= load_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register, 1-cycle latency, valid/ready with flush; PIPE_STAGE_SKID_EN adds a skid slot so
// in_ready is a flop (!skid_valid), otherwise in_ready = !out_valid | out_ready combinationally.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  logic              accept;
  logic              drain;
  logic              main_valid;
  logic              main_load;
  logic              main_clear;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl_in;
  logic [DATA_W-1:0] main_data_in;

  assign accept = in_valid & in_ready;
  assign drain  = main_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic              skid_load;
  logic              skid_clear;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign in_ready = !skid_valid;

  // in_ready is low while skid is full, so a refill from skid never races a new accept.
  assign main_load    = (accept & (!main_valid | drain)) | (drain & skid_valid);
  assign main_clear   = flush | (drain & !accept & !skid_valid);
  assign main_ctrl_in = skid_valid ? skid_ctrl : in_ctrl;
  assign main_data_in = skid_valid ? skid_data : in_data;

  assign skid_load  = accept & main_valid & !drain;
  assign skid_clear = flush | (drain & skid_valid);

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_ctrl (in_ctrl),
    .load_data (in_data),
    .valid     (skid_valid),
    .ctrl      (skid_ctrl),
    .data      (skid_data)
  );

  assign count = {1'b0, main_valid} + {1'b0, skid_valid};
`else
  assign in_ready = !main_valid | out_ready;

  assign main_load    = accept;
  assign main_clear   = flush | (drain & !accept);
  assign main_ctrl_in = in_ctrl;
  assign main_data_in = in_data;

  assign count = {1'b0, main_valid};
`endif

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk       (clk),
    .rst       (rst),
    .load      (main_load),
    .clear     (main_clear),
    .load_ctrl (main_ctrl_in),
    .load_data (main_data_in),
    .valid     (main_valid),
    .ctrl      (main_ctrl),
    .data      (main_data)
  );

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised plus directed bench for pipe_stage_reg against a FIFO-queue reference model.
// Build with or without PIPE_STAGE_SKID_EN; the model capacity follows the macro.
module tb_pipe_stage_reg;

  localparam int CW = 23;
  localparam int DW = 72;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    count;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 0;
  ent_t exp_q[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .count     (count)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; model: queue of held entries, capacity CAP, FIFO order.
  task automatic cycle(input bit iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input bit ordy, input bit fl, input bit r);
    bit exp_rdy;
    bit acc;
    @(negedge clk);
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    #1;
    exp_rdy = (CAP == 2) ? (exp_q.size() < 2) : (exp_q.size() == 0 || ordy);
    chk("in_ready", 128'(in_ready), 128'(exp_rdy));
    chk("count", 128'(count), 128'(exp_q.size()));
    chk("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
    acc = iv && exp_rdy;
    @(posedge clk);
    #1;
    if (r || fl) exp_q.delete();
    else if (acc) exp_q.push_back('{c: c, d: d});
  endtask

  // Monitor: head must match the oldest expected entry; pop on release.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: got ctrl %0h with empty model", out_ctrl);
          end else begin
            chk("out_ctrl", 128'(out_ctrl), 128'(exp_q[0].c));
            chk("out_data", 128'(out_data), 128'(exp_q[0].d));
            if (out_ready) void'(exp_q.pop_front());
          end
        end else begin
          chk("bubble_ctrl", 128'(out_ctrl), 128'(0));
          chk("bubble_data", 128'(out_data), 128'(0));
        end
      end
    end
  end

  function automatic logic [DW-1:0] rnd_data();
    logic [95:0] w;
    w = {$urandom(), $urandom(), $urandom()};
    return w[DW-1:0];
  endfunction

  initial begin
    logic [CW-1:0] rc;
    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1;

    // Reset then idle.
    cycle(0, '0, '0, 0, 0, 1);
    cycle(0, '0, '0, 0, 0, 0);
    cycle(0, '0, '0, 1, 0, 0);

    // Streaming with out_ready held high.
    for (int i = 1; i <= 8; i++) cycle(1, CW'(i), DW'(i * 3), 1, 0, 0);
    cycle(0, '0, '0, 1, 0, 0);
    cycle(0, '0, '0, 1, 0, 0);

    // Stall: A then B while out_ready low, then release.
    cycle(1, CW'(23'h0000A), DW'(72'hA), 0, 0, 0);
    cycle(1, CW'(23'h0000B), DW'(72'hB), 0, 0, 0);
    cycle(1, CW'(23'h0000B), DW'(72'hB), 0, 0, 0);
    if (CAP == 1) cycle(1, CW'(23'h0000B), DW'(72'hB), 1, 0, 0);
    cycle(0, '0, '0, 1, 0, 0);
    cycle(0, '0, '0, 1, 0, 0);
    cycle(0, '0, '0, 1, 0, 0);

    // Flush with concurrent accept of a value that must never appear.
    cycle(1, CW'(23'h7FFFFF), DW'(72'h55), 0, 0, 0);
    cycle(1, CW'(23'h12345), DW'(72'h66), 0, 1, 0);
    cycle(0, '0, '0, 1, 0, 0);
    cycle(0, '0, '0, 1, 0, 0);

    // Reset in the middle of a stall.
    cycle(1, CW'(23'h00011), DW'(72'h11), 0, 0, 0);
    cycle(1, CW'(23'h00022), DW'(72'h22), 0, 0, 0);
    cycle(0, '0, '0, 0, 0, 1);
    cycle(0, '0, '0, 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rc = CW'($urandom());
      cycle($urandom_range(0, 9) < 6, rc, rnd_data(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
    end

    // Drain: everything left must come out in order.
    for (int i = 0; i < 4; i++) cycle(0, '0, '0, 1, 0, 0);
    chk("drained", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
